// File: rtl/writeback_arbiter_pkg.sv
// Shared decode-stage definitions for the register-bank writeback path:
// register address/data widths, the hard-wired zero register and a small
// wrap-around helper used by the round-robin scan.
package writeback_arbiter_pkg;

    localparam int REG_ADDR_WIDTH = 5;
    localparam int REG_DATA_WIDTH = 32;

    // Register 0 reads as zero and must never be written.
    localparam logic [REG_ADDR_WIDTH-1:0] REG_ZERO = 5'd0;

    // Modulo-n increment for indices that are not necessarily a power of two.
    function automatic int wrap_inc(input int idx, input int n);
        int nxt;
        nxt = idx + 32'sd1;
        if (nxt >= n) begin
            nxt = 32'sd0;
        end else begin
            nxt = nxt;
        end
        return nxt;
    endfunction

endpackage

// File: rtl/writeback_arbiter_wb_fifo.sv
// Single-producer result FIFO: stores (address, data) pairs, exposes the head
// entry and full/empty flags. Pointers carry one extra wrap bit so full and
// empty are distinguished without a separate counter.
module wb_fifo
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = REG_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = REG_ADDR_WIDTH,
    parameter int DEPTH         = 2
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [ADDRESS_WIDTH-1:0] push_addr,
    input  logic [DATA_WIDTH-1:0]    push_data,
    output logic                     full,
    output logic                     empty,
    output logic [ADDRESS_WIDTH-1:0] head_addr,
    output logic [DATA_WIDTH-1:0]    head_data
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = {{(PTR_W-1){1'b0}}, 1'b1};

    logic [PTR_W-1:0]         wr_ptr_r;
    logic [PTR_W-1:0]         rd_ptr_r;
    logic [ADDRESS_WIDTH-1:0] addr_mem_r [DEPTH];
    logic [DATA_WIDTH-1:0]    data_mem_r [DEPTH];
    logic                     full_s;
    logic                     empty_s;
    logic                     do_push_s;
    logic                     do_pop_s;

    assign full_s  = (wr_ptr_r[PTR_W-1] != rd_ptr_r[PTR_W-1]) &&
                     (wr_ptr_r[IDX_W-1:0] == rd_ptr_r[IDX_W-1:0]);
    assign empty_s = (wr_ptr_r == rd_ptr_r);

    // A push into a full FIFO or a pop from an empty one is ignored.
    assign do_push_s = push & ~full_s;
    assign do_pop_s  = pop & ~empty_s;

    assign full      = full_s;
    assign empty     = empty_s;
    assign head_addr = addr_mem_r[rd_ptr_r[IDX_W-1:0]];
    assign head_data = data_mem_r[rd_ptr_r[IDX_W-1:0]];

    // Pointer update; flush discards all buffered entries.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else if (flush) begin
            wr_ptr_r <= {PTR_W{1'b0}};
            rd_ptr_r <= {PTR_W{1'b0}};
        end else begin
            if (do_push_s) wr_ptr_r <= wr_ptr_r + PTR_ONE;
            if (do_pop_s)  rd_ptr_r <= rd_ptr_r + PTR_ONE;
        end
    end

    // Entry storage, written at the tail slot on an accepted push.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                addr_mem_r[i] <= {ADDRESS_WIDTH{1'b0}};
                data_mem_r[i] <= {DATA_WIDTH{1'b0}};
            end
        end else if (do_push_s && !flush) begin
            addr_mem_r[wr_ptr_r[IDX_W-1:0]] <= push_addr;
            data_mem_r[wr_ptr_r[IDX_W-1:0]] <= push_data;
        end
    end

endmodule

// File: rtl/writeback_arbiter.sv
// Writeback arbiter for the register bank's dual write ports. Each producer
// feeds its own FIFO; every cycle up to two heads are retired in round-robin
// order onto ports a/b, never both to the same register, and writes to
// register 0 are swallowed (popped but not enabled).
module writeback_arbiter
    import writeback_arbiter_pkg::*;
#(
    parameter int DATA_WIDTH    = REG_DATA_WIDTH,
    parameter int ADDRESS_WIDTH = REG_ADDR_WIDTH,
    parameter int N_SRC         = 3,
    parameter int FIFO_DEPTH    = 2
) (
    input  logic                             clk,
    input  logic                             rst_n,
    input  logic                             flush,
    input  logic [N_SRC-1:0]                 src_valid,
    output logic [N_SRC-1:0]                 src_ready,
    input  logic [N_SRC*ADDRESS_WIDTH-1:0]   src_addr,
    input  logic [N_SRC*DATA_WIDTH-1:0]      src_data,
    output logic                             reg_a_wr_en,
    output logic [ADDRESS_WIDTH-1:0]         reg_a_wr_addr,
    output logic [DATA_WIDTH-1:0]            reg_a_wr_data,
    output logic                             reg_b_wr_en,
    output logic [ADDRESS_WIDTH-1:0]         reg_b_wr_addr,
    output logic [DATA_WIDTH-1:0]            reg_b_wr_data,
    output logic                             busy
);

    localparam int RR_W = $clog2(N_SRC);
    localparam logic [ADDRESS_WIDTH-1:0] ZERO_ADDR = ADDRESS_WIDTH'(REG_ZERO);

    logic [N_SRC-1:0]         full_s;
    logic [N_SRC-1:0]         empty_s;
    logic [N_SRC-1:0]         push_s;
    logic [N_SRC-1:0]         pop_s;
    logic [ADDRESS_WIDTH-1:0] head_addr_s [N_SRC];
    logic [DATA_WIDTH-1:0]    head_data_s [N_SRC];

    logic [RR_W-1:0]          rr_ptr_r;
    logic [RR_W-1:0]          rr_next_s;
    logic                     grant_a_s;
    logic                     grant_b_s;
    logic [RR_W-1:0]          idx_a_s;
    logic [RR_W-1:0]          idx_b_s;
    logic                     a_en_s;
    logic                     b_en_s;

    // Ready depends on FIFO occupancy only; flush drops incoming beats.
    assign src_ready = ~full_s;
    assign push_s    = src_valid & ~full_s & {N_SRC{~flush}};
    assign busy      = (|(~empty_s)) | reg_a_wr_en | reg_b_wr_en;

    for (genvar g = 0; g < N_SRC; g++) begin : g_fifo
        wb_fifo #(
            .DATA_WIDTH    (DATA_WIDTH),
            .ADDRESS_WIDTH (ADDRESS_WIDTH),
            .DEPTH         (FIFO_DEPTH)
        ) u_fifo (
            .clk       (clk),
            .rst_n     (rst_n),
            .flush     (flush),
            .push      (push_s[g]),
            .pop       (pop_s[g]),
            .push_addr (src_addr[g*ADDRESS_WIDTH +: ADDRESS_WIDTH]),
            .push_data (src_data[g*DATA_WIDTH +: DATA_WIDTH]),
            .full      (full_s[g]),
            .empty     (empty_s[g]),
            .head_addr (head_addr_s[g]),
            .head_data (head_data_s[g])
        );
    end

    // Round-robin scan from rr_ptr: first non-empty head is A, next head with
    // a different address is B; same-address heads wait to keep order sane.
    always_comb begin
        int               scan_idx;
        logic [RR_W-1:0]  scan_s;
        logic [RR_W-1:0]  last_s;
        grant_a_s = 1'b0;
        grant_b_s = 1'b0;
        idx_a_s   = {RR_W{1'b0}};
        idx_b_s   = {RR_W{1'b0}};
        pop_s     = {N_SRC{1'b0}};
        rr_next_s = rr_ptr_r;
        scan_idx  = 32'sd0;
        scan_s    = {RR_W{1'b0}};
        last_s    = {RR_W{1'b0}};
        for (int k = 0; k < N_SRC; k++) begin
            scan_idx = int'(rr_ptr_r) + k;
            scan_idx = (scan_idx >= N_SRC) ? (scan_idx - N_SRC) : scan_idx;
            scan_s   = RR_W'(scan_idx);
            if (!empty_s[scan_s]) begin
                if (!grant_a_s) begin
                    grant_a_s = 1'b1;
                    idx_a_s   = scan_s;
                end else if (!grant_b_s && (head_addr_s[scan_s] != head_addr_s[idx_a_s])) begin
                    grant_b_s = 1'b1;
                    idx_b_s   = scan_s;
                end else begin
                    grant_b_s = grant_b_s;
                end
            end else begin
                grant_a_s = grant_a_s;
            end
        end
        if (grant_a_s) begin
            pop_s[idx_a_s] = 1'b1;
        end else begin
            pop_s = pop_s;
        end
        if (grant_b_s) begin
            pop_s[idx_b_s] = 1'b1;
            last_s         = idx_b_s;
        end else begin
            last_s         = idx_a_s;
        end
        if (grant_a_s) begin
            rr_next_s = RR_W'(wrap_inc(int'(last_s), N_SRC));
        end else begin
            rr_next_s = rr_ptr_r;
        end
    end

    // Register-0 heads are consumed but never enabled onto a write port.
    assign a_en_s = grant_a_s && (head_addr_s[idx_a_s] != ZERO_ADDR);
    assign b_en_s = grant_b_s && (head_addr_s[idx_b_s] != ZERO_ADDR);

    // Output registers and round-robin pointer; address/data hold when idle.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            reg_a_wr_en   <= 1'b0;
            reg_a_wr_addr <= {ADDRESS_WIDTH{1'b0}};
            reg_a_wr_data <= {DATA_WIDTH{1'b0}};
            reg_b_wr_en   <= 1'b0;
            reg_b_wr_addr <= {ADDRESS_WIDTH{1'b0}};
            reg_b_wr_data <= {DATA_WIDTH{1'b0}};
            rr_ptr_r      <= {RR_W{1'b0}};
        end else if (flush) begin
            reg_a_wr_en   <= 1'b0;
            reg_b_wr_en   <= 1'b0;
            rr_ptr_r      <= {RR_W{1'b0}};
        end else begin
            reg_a_wr_en <= a_en_s;
            reg_b_wr_en <= b_en_s;
            rr_ptr_r    <= rr_next_s;
            if (a_en_s) begin
                reg_a_wr_addr <= head_addr_s[idx_a_s];
                reg_a_wr_data <= head_data_s[idx_a_s];
            end
            if (b_en_s) begin
                reg_b_wr_addr <= head_addr_s[idx_b_s];
                reg_b_wr_data <= head_data_s[idx_b_s];
            end
        end
    end

endmodule

// File: tb/tb_writeback_arbiter.sv
// Self-checking bench for writeback_arbiter: directed cycle-exact checks for
// latency, dual retire, collision, register-0, backpressure, flush and reset,
// plus a per-producer scoreboard that every observed write must match.
module tb_writeback_arbiter;

    localparam int DW = 32;
    localparam int AW = 5;
    localparam int NS = 3;
    localparam int FD = 2;

    logic              clk = 1'b0;
    logic              rst_n;
    logic              flush;
    logic [NS-1:0]     src_valid;
    logic [NS-1:0]     src_ready;
    logic [NS*AW-1:0]  src_addr;
    logic [NS*DW-1:0]  src_data;
    logic              reg_a_wr_en;
    logic [AW-1:0]     reg_a_wr_addr;
    logic [DW-1:0]     reg_a_wr_data;
    logic              reg_b_wr_en;
    logic [AW-1:0]     reg_b_wr_addr;
    logic [DW-1:0]     reg_b_wr_data;
    logic              busy;

    int n_checks = 0;
    int n_errors = 0;

    // Expected writes per producer, in acceptance order (register 0 excluded).
    logic [AW+DW-1:0] sb_q [NS][$];

    int   bp_idx [NS];
    logic bp_acc [NS];
    logic low_seen;
    int   cycles;

    writeback_arbiter #(
        .DATA_WIDTH    (DW),
        .ADDRESS_WIDTH (AW),
        .N_SRC         (NS),
        .FIFO_DEPTH    (FD)
    ) dut (
        .clk           (clk),
        .rst_n         (rst_n),
        .flush         (flush),
        .src_valid     (src_valid),
        .src_ready     (src_ready),
        .src_addr      (src_addr),
        .src_data      (src_data),
        .reg_a_wr_en   (reg_a_wr_en),
        .reg_a_wr_addr (reg_a_wr_addr),
        .reg_a_wr_data (reg_a_wr_data),
        .reg_b_wr_en   (reg_b_wr_en),
        .reg_b_wr_addr (reg_b_wr_addr),
        .reg_b_wr_data (reg_b_wr_data),
        .busy          (busy)
    );

    // Free-running clock.
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic sb_match(input string port, input logic [AW-1:0] a, input logic [DW-1:0] d);
        logic found;
        found = 1'b0;
        for (int i = 0; i < NS; i++) begin
            if (!found && sb_q[i].size() > 0 && sb_q[i][0] == {a, d}) begin
                void'(sb_q[i].pop_front());
                found = 1'b1;
            end
        end
        check_eq($sformatf("%s_write r%0d=0x%08h expected", port, a, d), 64'(found), 64'd1);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_beat(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d);
        src_valid[i]          = 1'b1;
        src_addr[i*AW +: AW]  = a;
        src_data[i*DW +: DW]  = d;
    endtask

    // Scoreboard monitor: compare presented writes, then record beats that
    // will be accepted at the coming rising edge.
    always @(negedge clk) begin
        if (rst_n) begin
            if (reg_a_wr_en) begin
                sb_match("a", reg_a_wr_addr, reg_a_wr_data);
                check_eq("a_addr_nonzero", 64'(reg_a_wr_addr != 5'd0), 64'd1);
            end
            if (reg_b_wr_en) begin
                sb_match("b", reg_b_wr_addr, reg_b_wr_data);
                check_eq("b_addr_nonzero", 64'(reg_b_wr_addr != 5'd0), 64'd1);
            end
            if (reg_a_wr_en && reg_b_wr_en) begin
                check_eq("ab_addr_differ", 64'(reg_a_wr_addr != reg_b_wr_addr), 64'd1);
            end
        end
        if (!rst_n || flush) begin
            for (int i = 0; i < NS; i++) sb_q[i].delete();
        end else begin
            for (int i = 0; i < NS; i++) begin
                if (src_valid[i] && src_ready[i] && src_addr[i*AW +: AW] != 5'd0) begin
                    sb_q[i].push_back({src_addr[i*AW +: AW], src_data[i*DW +: DW]});
                end
            end
        end
    end

    // Global time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: simulation did not complete");
        $fatal(1, "timeout");
    end

    // Directed stimulus and cycle-exact checks.
    initial begin
        rst_n     = 1'b0;
        flush     = 1'b0;
        src_valid = '0;
        src_addr  = '0;
        src_data  = '0;
        tick();
        check_eq("rst_a_en", 64'(reg_a_wr_en), 64'd0);
        check_eq("rst_b_en", 64'(reg_b_wr_en), 64'd0);
        tick();
        rst_n = 1'b1;
        #1;
        check_eq("rst_ready", 64'(src_ready), 64'h7);
        check_eq("rst_busy", 64'(busy), 64'd0);
        check_eq("rst_a_addr", 64'(reg_a_wr_addr), 64'd0);
        check_eq("rst_a_data", 64'(reg_a_wr_data), 64'd0);
        check_eq("rst_b_addr", 64'(reg_b_wr_addr), 64'd0);
        check_eq("rst_b_data", 64'(reg_b_wr_data), 64'd0);

        // Dual retire from src0 and src2 with rr_ptr at 0.
        set_beat(0, 5'd3, 32'h11);
        set_beat(2, 5'd7, 32'h22);
        tick();
        src_valid = '0;
        check_eq("dual_busy_buffered", 64'(busy), 64'd1);
        tick();
        check_eq("dual_a_en", 64'(reg_a_wr_en), 64'd1);
        check_eq("dual_a_addr", 64'(reg_a_wr_addr), 64'd3);
        check_eq("dual_a_data", 64'(reg_a_wr_data), 64'h11);
        check_eq("dual_b_en", 64'(reg_b_wr_en), 64'd1);
        check_eq("dual_b_addr", 64'(reg_b_wr_addr), 64'd7);
        check_eq("dual_b_data", 64'(reg_b_wr_data), 64'h22);
        tick();
        check_eq("dual_idle_a", 64'(reg_a_wr_en), 64'd0);
        check_eq("dual_idle_busy", 64'(busy), 64'd0);

        // Same-address collision: src0 wins (rr_ptr back at 0), src1 next cycle.
        set_beat(0, 5'd9, 32'hAA);
        set_beat(1, 5'd9, 32'hBB);
        tick();
        src_valid = '0;
        tick();
        check_eq("coll1_a_en", 64'(reg_a_wr_en), 64'd1);
        check_eq("coll1_a_addr", 64'(reg_a_wr_addr), 64'd9);
        check_eq("coll1_a_data", 64'(reg_a_wr_data), 64'hAA);
        check_eq("coll1_b_en", 64'(reg_b_wr_en), 64'd0);
        tick();
        check_eq("coll2_a_en", 64'(reg_a_wr_en), 64'd1);
        check_eq("coll2_a_addr", 64'(reg_a_wr_addr), 64'd9);
        check_eq("coll2_a_data", 64'(reg_a_wr_data), 64'hBB);
        check_eq("coll2_b_en", 64'(reg_b_wr_en), 64'd0);
        tick();
        check_eq("coll_done_a_en", 64'(reg_a_wr_en), 64'd0);

        // Single beat: presented after E1, idle after E2.
        set_beat(0, 5'd5, 32'hDEADBEEF);
        tick();
        src_valid = '0;
        check_eq("single_busy_e0", 64'(busy), 64'd1);
        tick();
        check_eq("single_a_en", 64'(reg_a_wr_en), 64'd1);
        check_eq("single_a_addr", 64'(reg_a_wr_addr), 64'd5);
        check_eq("single_a_data", 64'(reg_a_wr_data), 64'hDEADBEEF);
        check_eq("single_b_en", 64'(reg_b_wr_en), 64'd0);
        tick();
        check_eq("single_busy_e2", 64'(busy), 64'd0);
        check_eq("single_a_en_e2", 64'(reg_a_wr_en), 64'd0);

        // Register-0 beat is consumed without a write.
        set_beat(1, 5'd0, 32'hFFFF);
        tick();
        src_valid = '0;
        check_eq("r0_ready1", 64'(src_ready[1]), 64'd1);
        check_eq("r0_busy_buffered", 64'(busy), 64'd1);
        tick();
        check_eq("r0_a_en", 64'(reg_a_wr_en), 64'd0);
        check_eq("r0_b_en", 64'(reg_b_wr_en), 64'd0);
        check_eq("r0_busy", 64'(busy), 64'd0);
        check_eq("r0_ready_all", 64'(src_ready), 64'h7);
        check_eq("r0_a_addr_hold", 64'(reg_a_wr_addr), 64'd5);

        // Flush on an idle block returns rr_ptr to 0 for the next phase.
        flush = 1'b1;
        tick();
        flush = 1'b0;
        check_eq("flush_idle_busy", 64'(busy), 64'd0);

        // Backpressure: src0 pushes 4 beats while src1/src2 stream.
        low_seen = 1'b0;
        for (int i = 0; i < NS; i++) bp_idx[i] = 0;
        for (int cyc = 0; cyc < 12; cyc++) begin
            for (int i = 0; i < NS; i++) begin
                if ((i == 0 && bp_idx[0] < 4) || (i != 0 && cyc < 10)) begin
                    set_beat(i, AW'(8 + 8 * i + (bp_idx[i] % 4)), DW'((i << 24) | bp_idx[i]));
                end else begin
                    src_valid[i] = 1'b0;
                end
                bp_acc[i] = src_valid[i] & src_ready[i];
            end
            if (!src_ready[0]) low_seen = 1'b1;
            tick();
            for (int i = 0; i < NS; i++) if (bp_acc[i]) bp_idx[i]++;
        end
        src_valid = '0;
        check_eq("bp_ready0_deasserted", 64'(low_seen), 64'd1);
        check_eq("bp_src0_beats", 64'(bp_idx[0]), 64'd4);
        cycles = 0;
        while (busy && cycles < 50) begin
            tick();
            cycles++;
        end
        check_eq("bp_drain_busy", 64'(busy), 64'd0);
        tick();
        for (int i = 0; i < NS; i++) check_eq($sformatf("bp_sb_empty%0d", i), 64'(sb_q[i].size()), 64'd0);

        // Flush mid-stream: all buffered results and the next write vanish.
        for (int cyc = 0; cyc < 3; cyc++) begin
            for (int i = 0; i < NS; i++) set_beat(i, AW'(1 + 4 * i + cyc), DW'(32'h100 * (i + 1) + cyc));
            tick();
        end
        flush = 1'b1;
        tick();
        flush     = 1'b0;
        src_valid = '0;
        check_eq("flush_a_en", 64'(reg_a_wr_en), 64'd0);
        check_eq("flush_b_en", 64'(reg_b_wr_en), 64'd0);
        check_eq("flush_busy", 64'(busy), 64'd0);
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            check_eq("flush_after_en", 64'(reg_a_wr_en | reg_b_wr_en), 64'd0);
        end

        // Asynchronous reset mid-stream: outputs return to zero at once.
        for (int cyc = 0; cyc < 3; cyc++) begin
            for (int i = 0; i < NS; i++) set_beat(i, AW'(17 + 4 * i + cyc), DW'(32'h5000 * (i + 1) + cyc));
            tick();
        end
        rst_n     = 1'b0;
        src_valid = '0;
        #1;
        check_eq("arst_a_en", 64'(reg_a_wr_en), 64'd0);
        check_eq("arst_b_en", 64'(reg_b_wr_en), 64'd0);
        check_eq("arst_a_addr", 64'(reg_a_wr_addr), 64'd0);
        check_eq("arst_a_data", 64'(reg_a_wr_data), 64'd0);
        check_eq("arst_b_addr", 64'(reg_b_wr_addr), 64'd0);
        check_eq("arst_b_data", 64'(reg_b_wr_data), 64'd0);
        check_eq("arst_busy", 64'(busy), 64'd0);
        check_eq("arst_ready", 64'(src_ready), 64'h7);
        tick();
        tick();
        rst_n = 1'b1;
        for (int cyc = 0; cyc < 3; cyc++) begin
            tick();
            check_eq("arst_after_en", 64'(reg_a_wr_en | reg_b_wr_en), 64'd0);
            check_eq("arst_after_busy", 64'(busy), 64'd0);
        end
        for (int i = 0; i < NS; i++) check_eq($sformatf("final_sb_empty%0d", i), 64'(sb_q[i].size()), 64'd0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/writeback_arbiter.md
Name: writeback_arbiter

Overview:
- Writer side of the general-purpose register bank's dual write ports (a/b).
- Collects results from N_SRC execution producers (ALU, load unit, multiplier, ...) over valid/ready handshakes.
- Buffers each producer in a small FIFO and retires up to two results per cycle onto the a/b write ports.
- Guarantees that the a and b ports never target the same register in the same cycle, and that register 0 is never written.

Parameters:
- DATA_WIDTH, 32, width of result data and write data.
- ADDRESS_WIDTH, 5, register address width.
- N_SRC, 3, number of producer interfaces (2..8).
- FIFO_DEPTH, 2, entries per producer FIFO; power of two, at least 2.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous, active-low reset.
- flush  in  1  synchronous flush: discards all buffered results and drops outputs.
- src_valid  in  N_SRC  per-producer result valid.
- src_ready  out  N_SRC  per-producer ready (its FIFO is not full).
- src_addr  in  N_SRC*ADDRESS_WIDTH  destination register, packed; producer i uses slice i.
- src_data  in  N_SRC*DATA_WIDTH  result data, packed.
- reg_a_wr_en  out  1  write enable, port a.
- reg_a_wr_addr  out  ADDRESS_WIDTH  write address, port a.
- reg_a_wr_data  out  DATA_WIDTH  write data, port a.
- reg_b_wr_en  out  1  write enable, port b.
- reg_b_wr_addr  out  ADDRESS_WIDTH  write address, port b.
- reg_b_wr_data  out  DATA_WIDTH  write data, port b.
- busy  out  1  high while any FIFO is non-empty or either write enable is high.

Behaviour:
- Reset: all FIFOs empty, round-robin pointer = 0, and every write output (enables, addresses, data) = 0. src_ready = all ones from the first cycle after reset. busy = 0.
- Handshake: a beat transfers on a rising edge where src_valid[i] && src_ready[i]. src_ready[i] = !full[i] and is combinational from FIFO state only, never from src_valid.
- FIFO: one per producer, with registered read/write pointers that carry one extra wrap bit.
  - full when the pointers differ only in the wrap bit; empty when they are equal.
  - A simultaneous push and pop on a full FIFO is allowed only if src_ready was already high, so no push occurs while full.
- Arbitration, each cycle, over non-empty FIFO heads:
  - Scan producers in order starting at rr_ptr.
  - The first non-empty head is grant A.
  - The next non-empty head whose address differs from grant A's address is grant B.
  - A head with the same address as grant A is skipped this cycle; it stays at its FIFO head and preserves per-producer order.
- Register 0: a head with address 0 may still be granted and popped, but its write enable is forced to 0. It still consumes its slot.
- Output registers, loaded on each edge:
  - reg_a_wr_en = grant A exists && address != 0, and likewise for port b.
  - Address and data are loaded from the granted heads. When the enable is 0, address and data hold their previous value.
  - Latency: a beat accepted at edge E0 is presented on the write port after edge E1 and is committed in the bank at E2. There are no bubbles under continuous traffic.
- Round-robin: when at least one grant occurs, rr_ptr advances to (index of last grant + 1) mod N_SRC; otherwise it holds.
- Ordering: FIFO order is preserved within a producer. Across producers there is no ordering guarantee; the issue stage must not have two in-flight writes to the same register from different producers.
- flush, on the edge where it is sampled high:
  - All FIFO pointers clear.
  - Both write enables go to 0.
  - Incoming beats in that cycle are dropped.
  - rr_ptr resets to 0.
- Asynchronous reset mid-traffic: immediate return to reset values; no partial write is emitted.
- busy is combinational from the FIFO empty flags and the registered enables.

Decomposition:
- Shared package for the decode stage: register-address width, register-0 constant, and data width.
- Sub-module wb_fifo: a parameterised single-producer FIFO with push/pop, full/empty and head outputs, instantiated N_SRC times via generate.
- The arbiter and output registers live in the top module.

Test Plan:
- Single beat: src0 sends addr=5, data=0xDEADBEEF at E0 -> reg_a_wr_en=1, addr 5, data 0xDEADBEEF after E1; port b idle; busy=0 after E2.
- Dual retire: src0 addr=3, data=0x11 and src2 addr=7, data=0x22 in the same cycle, rr_ptr=0 -> port a writes r3=0x11 and port b writes r7=0x22 in the same cycle; rr_ptr becomes 0.
- Address collision: src0 and src1 both target addr=9 (0xAA, 0xBB) -> cycle 1 writes only port a (r9=0xAA); the next cycle writes r9=0xBB; port b never drives r9 concurrently.
- Register-0 drop: src1 sends addr=0, data=0xFFFF -> no write enable asserted; FIFO pops; src_ready[1] stays 1.
- Backpressure: hold src0 valid for 4 beats while the other producers stream to occupy the ports -> src_ready[0] deasserts after 2 buffered beats; all 4 beats are eventually written in order with none lost.
- Flush and reset: fill all FIFOs, assert flush for 1 cycle -> no write enables afterwards and busy=0. Repeat with rst_n pulsed low mid-stream -> outputs are 0 immediately.
